// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    function automatic int cnt_w(input int len);
        return $clog2(len);
    endfunction

    // XOR of all bits: appending it makes the count of ones even.
    function automatic logic parity_even(input logic [63:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Loadable down-counter for the bits left in a frame; tc flags the final bit.
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int FRAME_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic tc
);

    localparam int            CW  = cnt_w(FRAME_LEN);
    localparam logic [CW-1:0] TOP = CW'(FRAME_LEN - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      cnt <= '0;
        else if (load) cnt <= TOP;
        else if (en)   cnt <= cnt - CW'(1);
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter with valid/ready on both sides and gapless frames.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             serial_valid,
    input  logic             serial_ready,
    output logic             serial_last,
    output logic             busy
);

`ifdef PISO_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif

    state_e               state, state_nxt;
    logic [FRAME_LEN-1:0] shift_reg, frame;
    logic [FRAME_LEN-1:0] frame_rest, reg_rest;
    logic                 frame_head, reg_head;
    logic                 load_fire, adv, tc;

    // Parity rides at the tail of the frame whichever end is sent first.
    always_comb begin
`ifdef PISO_PARITY_EN
        if (MSB_FIRST) frame = {parallel_in, parity_even(64'(parallel_in))};
        else           frame = {parity_even(64'(parallel_in)), parallel_in};
`else
        frame = parallel_in;
`endif
    end

    assign frame_head = MSB_FIRST ? frame[FRAME_LEN-1]     : frame[0];
    assign frame_rest = MSB_FIRST ? (frame << 1)           : (frame >> 1);
    assign reg_head   = MSB_FIRST ? shift_reg[FRAME_LEN-1] : shift_reg[0];
    assign reg_rest   = MSB_FIRST ? (shift_reg << 1)       : (shift_reg >> 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        load_ready = 1'b0;
        case (state)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (serial_ready && tc) begin
                    load_ready = 1'b1;
                    if (!load_valid) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign serial_valid = (state == SHIFT);
    assign busy         = (state == SHIFT);
    assign serial_last  = serial_valid && tc;
    assign adv          = serial_valid && serial_ready;
    assign load_fire    = load_valid && load_ready;

    // A new load wins over the final-bit advance so back-to-back frames have no bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg  <= '0;
            serial_out <= 1'b0;
        end else if (load_fire) begin
            serial_out <= frame_head;
            shift_reg  <= frame_rest;
        end else if (adv) begin
            serial_out <= tc ? 1'b0 : reg_head;
            shift_reg  <= reg_rest;
        end
    end

    piso_bit_counter #(
        .FRAME_LEN(FRAME_LEN)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .load(load_fire),
        .en  (adv && !tc),
        .tc  (tc)
    );

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: LSB- and MSB-first instances against a queue-based frame model.
`timescale 1ns/1ps
module tb_piso_serializer;

    localparam int W = 8;
`ifdef PISO_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] parallel_in = '0;
    logic         load_valid = 1'b0;
    logic         serial_ready = 1'b0;
    logic         lr0, so0, sv0, sl0, b0;
    logic         lr1, so1, sv1, sl1, b1;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    bit q0[$];
    bit q1[$];
    bit c0[$];
    bit c1[$];
    bit cl[$];
    int ct[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .parallel_in(parallel_in), .load_valid(load_valid),
        .load_ready(lr0), .serial_out(so0), .serial_valid(sv0),
        .serial_ready(serial_ready), .serial_last(sl0), .busy(b0)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .parallel_in(parallel_in), .load_valid(load_valid),
        .load_ready(lr1), .serial_out(so1), .serial_valid(sv1),
        .serial_ready(serial_ready), .serial_last(sl1), .busy(b1)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    // Model: each queue holds the bits of the frame still to be sent, head = bit on the wire.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q0.delete();
            q1.delete();
        end else begin
            bit lr;
            lr = (q0.size() == 0) || (q0.size() == 1 && serial_ready);
            if (q0.size() != 0 && serial_ready) begin
                q0.delete(0);
                q1.delete(0);
            end
            if (load_valid && lr) begin
                for (int i = 0; i < W; i++) begin
                    q0.push_back(parallel_in[i]);
                    q1.push_back(parallel_in[W-1-i]);
                end
`ifdef PISO_PARITY_EN
                q0.push_back(^parallel_in);
                q1.push_back(^parallel_in);
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            logic       mv, ml, mlr;
            logic [9:0] e, a;
            mv  = (q0.size() != 0);
            ml  = (q0.size() == 1);
            mlr = !mv || (ml && serial_ready);
            e = {mlr, mv, ml, mv, mv ? q0[0] : 1'b0, mlr, mv, ml, mv, mv ? q1[0] : 1'b0};
            a = {lr0, sv0, sl0, b0, so0, lr1, sv1, sl1, b1, so1};
            chk("cycle", 64'(a), 64'(e));
            if (sv0 && serial_ready) begin
                c0.push_back(so0);
                c1.push_back(so1);
                cl.push_back(sl0);
                ct.push_back(cyc);
            end
        end
    end

    function automatic logic [63:0] pk(input bit q[$], input int start, input int n, input bit rev);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < n; i++)
            if (start + i < q.size()) begin
                if (rev) v[n-1-i] = q[start+i];
                else     v[i]     = q[start+i];
            end
        return v;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr();
        c0.delete();
        c1.delete();
        cl.delete();
        ct.delete();
    endtask

    // Call at #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send(input logic [W-1:0] w, input bit keep);
        bit ok;
        ok = 1'b0;
        parallel_in = w;
        load_valid  = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = lr0;
            @(posedge clk);
            #1;
        end
        if (!keep) load_valid = 1'b0;
        chk("load_hs", 64'(ok), 64'd1);
    endtask

    initial begin
        bit acc;
        tick(2);
        chk("rst_out", 64'({sv0, so0, sl0, b0, sv1, so1, sl1, b1}), 64'd0);
        #2 rst = 1'b1;
        serial_ready = 1'b1;
        tick(1);

        // Single frame, always-ready sink.
        clr();
        send(8'hA5, 1'b0);
        tick(FL + 2);
        chk("a5_beats", 64'(c0.size()), 64'(FL));
        chk("a5_lsb", pk(c0, 0, W, 1'b0), 64'hA5);
        chk("a5_msb", pk(c1, 0, W, 1'b1), 64'hA5);
        chk("a5_last", pk(cl, 0, FL, 1'b0), 64'd1 << (FL - 1));
        if (ct.size() == FL) chk("a5_span", 64'(ct[FL-1] - ct[0] + 1), 64'(FL));
        chk("a5_idle", 64'({b0, sv0, b1, sv1}), 64'd0);

        // Non-palindromic word pins bit order.
        clr();
        send(8'h01, 1'b0);
        tick(FL + 2);
        chk("ord_lsb_first", 64'(c0.size() > 0 ? c0[0] : 1'b0), 64'd1);
        chk("ord_msb_word", pk(c1, 0, W, 1'b1), 64'h01);
        chk("ord_msb_first", 64'(c1.size() > 0 ? c1[0] : 1'b1), 64'd0);

        // Back-to-back frames with load_valid held.
        clr();
        send(8'hFF, 1'b1);
        send(8'h00, 1'b0);
        tick(FL + 2);
        chk("b2b_beats", 64'(c0.size()), 64'(2 * FL));
        chk("b2b_bits", pk(c0, 0, 2 * FL, 1'b0), 64'hFF);
        if (ct.size() == 2 * FL) chk("b2b_span", 64'(ct[2*FL-1] - ct[0] + 1), 64'(2 * FL));

        // Three-cycle stall with bit 2 on the wire.
        clr();
        send(8'h3C, 1'b0);
        tick(2);
        serial_ready = 1'b0;
        tick(3);
        serial_ready = 1'b1;
        tick(FL + 2);
        chk("stall_beats", 64'(c0.size()), 64'(FL));
        chk("stall_lsb", pk(c0, 0, W, 1'b0), 64'h3C);
        chk("stall_msb", pk(c1, 0, W, 1'b1), 64'h3C);
        if (ct.size() == FL) chk("stall_span", 64'(ct[FL-1] - ct[0] + 1), 64'(FL + 3));

        // Asynchronous reset mid-frame, then a fresh frame.
        clr();
        send(8'h5A, 1'b0);
        tick(4);
        #3 rst = 1'b0;
        #1;
        chk("rst_async", 64'({sv0, so0, sl0, b0, sv1, so1, sl1, b1}), 64'd0);
        tick(1);
        rst = 1'b1;
        clr();
        #1;
        chk("rst_lr", 64'({lr0, lr1}), 64'd3);
        tick(1);
        send(8'h81, 1'b0);
        tick(FL + 2);
        chk("r81_beats", 64'(c0.size()), 64'(FL));
        chk("r81_lsb", pk(c0, 0, W, 1'b0), 64'h81);
        chk("r81_msb", pk(c1, 0, W, 1'b1), 64'h81);

        // Odd and even popcount words; the tail bit is the parity when enabled.
        clr();
        send(8'h07, 1'b0);
        tick(FL + 2);
        chk("w07_lsb", pk(c0, 0, W, 1'b0), 64'h07);
`ifdef PISO_PARITY_EN
        chk("w07_par", 64'(c0.size() == FL ? c0[W] : 1'b0), 64'd1);
        chk("w07_last", pk(cl, 0, FL, 1'b0), 64'h100);
`endif
        clr();
        send(8'h03, 1'b0);
        tick(FL + 2);
        chk("w03_lsb", pk(c0, 0, W, 1'b0), 64'h03);
`ifdef PISO_PARITY_EN
        chk("w03_par", 64'(c0.size() == FL ? c0[W] : 1'b1), 64'd0);
`endif

        // Random traffic: upstream holds its word until accepted, sink stalls at random.
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            acc = load_valid && lr0;
            @(posedge clk);
            #1;
            if (!load_valid || acc) begin
                load_valid  = ($urandom_range(0, 3) != 0);
                parallel_in = W'($urandom);
            end
            serial_ready = ($urandom_range(0, 4) != 0);
        end
        load_valid   = 1'b0;
        serial_ready = 1'b1;
        tick(FL + 3);
        chk("drain", 64'({b0, b1}), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
